// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU sequencer: ALU select codes, width defaults, FSM encoding.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_SEL_W  = 3;

    // ALU select codes; 3'b100..3'b111 are passed through and yield 0 from the ALU
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One ALU operation as presented by a requester
    typedef struct packed {
        logic [DEF_SEL_W-1:0]  sel;
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
    } alu_op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants the requester that was not served last when both are valid.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    input  logic update_id,
    output logic grant_valid_c,
    output logic grant_c
);

    logic last_grant;

    // Remember who completed last; reset value 1 lets requester 0 win the first contest
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= update_id;
        end
    end

    // Grant selection from the valid pair and the round-robin pointer
    always_comb begin
        grant_valid_c = valid0 | valid1;
        grant_c       = 1'b0;
        if (valid0 && valid1) begin
            grant_c = ~last_grant;
        end else if (valid1) begin
            grant_c = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: accept, hold operands for ALU_LAT cycles, return result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [SEL_W-1:0]  alu_select,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] count;
    logic             owner;
    logic             grant_valid_c;
    logic             grant_c;
    logic             accept_c;
    logic             sample_c;
    logic             done_c;
    logic             rsp_ready_own_c;

    rr_arb2 u_arb (
        .clk           (clk),
        .reset         (reset),
        .valid0        (req0_valid),
        .valid1        (req1_valid),
        .update        (done_c),
        .update_id     (owner),
        .grant_valid_c (grant_valid_c),
        .grant_c       (grant_c)
    );

    // State register; busy is registered from the next state so it tracks state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Next-state logic, handshake strobes and request-side ready
    always_comb begin
        state_next      = state;
        accept_c        = 1'b0;
        sample_c        = 1'b0;
        done_c          = 1'b0;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        rsp_ready_own_c = owner ? rsp1_ready : rsp0_ready;
        case (state)
            ST_IDLE: begin
                req0_ready = grant_valid_c && !grant_c;
                req1_ready = grant_valid_c && grant_c;
                if (grant_valid_c) begin
                    accept_c   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (count == '0) begin
                    sample_c   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_own_c) begin
                    done_c     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, settle counter, result capture and response valid flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_select <= '0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            owner      <= 1'b0;
            count      <= '0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                alu_select <= grant_c ? req1_sel : req0_sel;
                alu_data1  <= grant_c ? req1_a : req0_a;
                alu_data2  <= grant_c ? req1_b : req0_b;
                owner      <= grant_c;
                count      <= CNT_W'(ALU_LAT - 1);
            end
            if (state == ST_EXEC && count != '0) begin
                count <= count - CNT_W'(1);
            end
            if (sample_c) begin
                if (owner) begin
                    rsp1_data  <= alu_result;
                    rsp1_valid <= 1'b1;
                end else begin
                    rsp0_data  <= alu_result;
                    rsp0_valid <= 1'b1;
                end
            end
            if (done_c) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU and a round-robin reference model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int unsigned LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [2:0] req0_sel, req1_sel, alu_select;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(8), .SEL_W(3), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [7:0] ref_alu(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            ALU_FWD: return b;
            ALU_ADD: return 8'(a + b);
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural ALU driven by the DUT's registered operands
    always_comb alu_result = ref_alu(alu_select, alu_data1, alu_data2);

    task automatic drive_req(input int id, input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drive_req(0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive_req(1, 1'b0, 3'd0, 8'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_last = 1;
    endtask

    // Wait for ready on requester id, pass the accept edge, then drop its valid
    task automatic accept(input int id);
        int n;
        n = 0;
        #1;
        while (!((id == 0) ? req0_ready : req1_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL accept_timeout id=%0d: no ready seen, required ready within 20 cycles", id);
        end else begin
            @(posedge clk); #1;
        end
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Count edges after the accept edge until the response is valid
    task automatic wait_rsp(input int id, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!((id == 0) ? rsp0_valid : rsp1_valid) && cyc < 20);
    endtask

    // Full operation with response ready already high; ends back in IDLE
    task automatic run_op(input int id, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] data, output int lat);
        drive_req(id, 1'b1, s, a, b);
        accept(id);
        wait_rsp(id, lat);
        data = (id == 0) ? rsp0_data : rsp1_data;
        @(posedge clk); #1;
        model_last = id;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b rsp0_valid=%b rsp1_valid=%b, required 0 0 0", busy, rsp0_valid, rsp1_valid);
        end
        checks++;
        if ({alu_select, alu_data1, alu_data2, rsp0_data, rsp1_data} !== '0) begin
            errors++;
            $display("FAIL reset_regs: sel=%h d1=%h d2=%h r0=%h r1=%h, required all 0",
                     alu_select, alu_data1, alu_data2, rsp0_data, rsp1_data);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: req0_ready=%b req1_ready=%b, required 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_basic();
        int busy_cnt, lat;
        logic [7:0] data;
        rsp0_ready = 1'b1;
        drive_req(0, 1'b1, ALU_ADD, 8'd5, 8'd10);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: req0_ready=%b, required 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        busy_cnt = 0; lat = -1; data = 8'hxx;
        for (int i = 0; i < 7; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (rsp0_valid === 1'b1 && lat < 0) begin
                lat = i; data = rsp0_data;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != int'(LAT)) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, required %0d", lat, LAT);
        end
        checks++;
        if (data !== 8'd15) begin
            errors++;
            $display("FAIL basic_data: got %0d, required 15", data);
        end
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("FAIL basic_busy: busy high %0d cycles, required 3", busy_cnt);
        end
        model_last = 0;
    endtask

    task automatic test_contest();
        int lat;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive_req(0, 1'b1, ALU_AND, 8'hF0, 8'h3C);
        drive_req(1, 1'b1, ALU_OR, 8'h0F, 8'h30);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL contest_grant: req0_ready=%b req1_ready=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(0, lat);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h30) begin
            errors++;
            $display("FAIL contest_rsp0: valid=%b data=%h, required 1 30", rsp0_valid, rsp0_data);
        end
        checks++;
        if (rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL contest_rsp1_during_rsp0: rsp1_valid=%b, required 0", rsp1_valid);
        end
        model_last = 0;
        accept(1);
        wait_rsp(1, lat);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h3F) begin
            errors++;
            $display("FAIL contest_rsp1: valid=%b data=%h, required 1 3f", rsp1_valid, rsp1_data);
        end
        @(posedge clk); #1;
        model_last = 1;
    endtask

    task automatic test_alternation();
        int order [4];
        int n, cyc, exp_id;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive_req(0, 1'b1, ALU_ADD, 8'd1, 8'd2);
        drive_req(1, 1'b1, ALU_ADD, 8'd3, 8'd4);
        #1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            if (req0_ready === 1'b1) begin order[n] = 0; n++; end
            else if (req1_ready === 1'b1) begin order[n] = 1; n++; end
            @(posedge clk); #1; cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL alternation_count: got %0d grants, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            exp_id = 1 - model_last;
            model_last = exp_id;
            checks++;
            if (order[i] != exp_id) begin
                errors++;
                $display("FAIL alternation_order[%0d]: got requester %0d, required %0d", i, order[i], exp_id);
            end
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic test_backpressure();
        int lat;
        logic bad;
        logic [7:0] data;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drive_req(1, 1'b1, ALU_FWD, 8'd1, 8'd99);
        accept(1);
        wait_rsp(1, lat);
        drive_req(0, 1'b1, ALU_ADD, 8'd3, 8'd4);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 8'd99 || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
                bad = 1'b1;
                $display("FAIL backpressure_hold cycle %0d: rsp1_valid=%b data=%0d req0_ready=%b, required 1 99 0",
                         i, rsp1_valid, rsp1_data, req0_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bad) errors++;
        rsp1_ready = 1'b1; rsp0_ready = 1'b1;
        @(posedge clk); #1;
        model_last = 1;
        checks++;
        if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: rsp1_valid=%b req0_ready=%b, required 0 1", rsp1_valid, req0_ready);
        end
        accept(0);
        wait_rsp(0, lat);
        data = rsp0_data;
        @(posedge clk); #1;
        model_last = 0;
        checks++;
        if (data !== 8'd7) begin
            errors++;
            $display("FAIL backpressure_next: got %0d, required 7", data);
        end
    endtask

    task automatic test_wrap_undefined();
        logic [7:0] data;
        int lat;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        run_op(0, ALU_ADD, 8'd200, 8'd100, data, lat);
        checks++;
        if (data !== 8'd44) begin
            errors++;
            $display("FAIL wrap_add: got %0d, required 44", data);
        end
        run_op(0, 3'b100, 8'd77, 8'd33, data, lat);
        checks++;
        if (data !== 8'd0) begin
            errors++;
            $display("FAIL undefined_sel: got %0d, required 0", data);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic bad;
        logic [7:0] data;
        int lat;
        rsp0_ready = 1'b1;
        drive_req(0, 1'b1, ALU_OR, 8'h12, 8'h34);
        accept(0);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || {alu_select, alu_data1, alu_data2} !== '0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL midexec_reset: busy=%b sel=%h d1=%h d2=%h rsp0_valid=%b, required 0 0 0 0 0",
                     busy, alu_select, alu_data1, alu_data2, rsp0_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_last = 1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midexec_no_response: a response or busy appeared after reset, required none");
        end
        run_op(0, ALU_AND, 8'hAA, 8'h0F, data, lat);
        checks++;
        if (data !== 8'h0A || lat != int'(LAT)) begin
            errors++;
            $display("FAIL midexec_recover: data=%h lat=%0d, required 0a %0d", data, lat, LAT);
        end
    endtask

    task automatic test_random();
        alu_op_t op0, op1, win;
        logic v0, v1, bad;
        int exp_id, lat, d;
        logic [7:0] exp;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = '{sel: 3'($urandom_range(0, 7)), a: 8'($urandom_range(0, 255)), b: 8'($urandom_range(0, 255))};
            op1 = '{sel: 3'($urandom_range(0, 7)), a: 8'($urandom_range(0, 255)), b: 8'($urandom_range(0, 255))};
            exp_id = (v0 && v1) ? (1 - model_last) : (v0 ? 0 : 1);
            win = (exp_id == 0) ? op0 : op1;
            exp = ref_alu(win.sel, win.a, win.b);
            drive_req(0, v0, op0.sel, op0.a, op0.b);
            drive_req(1, v1, op1.sel, op1.a, op1.b);
            #1;
            checks++;
            if (req0_ready !== (exp_id == 0) || req1_ready !== (exp_id == 1)) begin
                errors++;
                $display("FAIL rand_grant it=%0d: ready0=%b ready1=%b, required winner %0d", it, req0_ready, req1_ready, exp_id);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_rsp(exp_id, lat);
            checks++;
            if (lat != int'(LAT)) begin
                errors++;
                $display("FAIL rand_latency it=%0d: got %0d, required %0d", it, lat, LAT);
            end
            d = int'($urandom_range(0, 3));
            bad = 1'b0;
            for (int h = 0; h <= d; h++) begin
                if (((exp_id == 0) ? rsp0_data : rsp1_data) !== exp ||
                    ((exp_id == 0) ? rsp1_valid : rsp0_valid) !== 1'b0 ||
                    ((exp_id == 0) ? rsp0_valid : rsp1_valid) !== 1'b1) bad = 1'b1;
                if (h < d) begin @(posedge clk); #1; end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand_data it=%0d: got %h (valid0=%b valid1=%b), required %h from requester %0d",
                         it, (exp_id == 0) ? rsp0_data : rsp1_data, rsp0_valid, rsp1_valid, exp, exp_id);
            end
            if (exp_id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(posedge clk); #1;
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            model_last = exp_id;
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_complete it=%0d: rsp0_valid=%b rsp1_valid=%b busy=%b, required 0 0 0",
                         it, rsp0_valid, rsp1_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contest();
        test_alternation();
        test_backpressure();
        test_wrap_undefined();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
